// File: rtl/adc_clk_sched_if.sv
// Job configuration channel into the ADC burst scheduler.
// A job {cfg_div, cfg_len} is transferred when cfg_valid & cfg_ready.
//   master : drives cfg_valid, cfg_div, cfg_len; receives cfg_ready
//   slave  : receives cfg_valid, cfg_div, cfg_len; drives cfg_ready
interface adc_clk_sched_if #(
  parameter int unsigned DIV_WIDTH = 12,
  parameter int unsigned LEN_WIDTH = 16
) ();
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [LEN_WIDTH-1:0] cfg_len;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_len,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_len,
    output cfg_ready
  );
endinterface

// File: rtl/adc_clk_sched.sv
// Burst scheduler for the integer ADC clock divider.
// Accepts a {div, len} job, holds the divider in reset for two cycles with the new ratio
// stable, then releases it and counts rising edges of the divided clock until len samples
// have been taken (len = 0: until stop_req). A burst never ends during a high phase.
//
// Optional feature: define ADC_SCHED_TIMEOUT_EN to add a watchdog that ends a burst with
// err = 1 when no rising edge is seen for TIMEOUT cycles in RUN. Without it err is tied 0.
//
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   cfg         job channel (slave side): cfg_valid/cfg_ready/cfg_div/cfg_len
//   stop_req    single-cycle request to end the running burst
//   adc_clk_in  divided clock returned from the divider (registered, clk domain)
//   div_out     ratio driven to the divider
//   div_rst_n   active-low reset driven to the divider
//   busy        high in ARM, RUN and STOP
//   sample_stb  one-cycle pulse per counted rising edge
//   sample_cnt  rising edges counted in the current burst
//   done        one-cycle pulse on burst end
//   err         one-cycle watchdog pulse
module adc_clk_sched #(
  parameter int unsigned DIV_WIDTH = 12,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adc_clk_sched_if.slave       cfg,
  input  logic                 stop_req,
  input  logic                 adc_clk_in,
  output logic [DIV_WIDTH-1:0] div_out,
  output logic                 div_rst_n,
  output logic                 busy,
  output logic                 sample_stb,
  output logic [LEN_WIDTH-1:0] sample_cnt,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic                 arm_cnt_q, arm_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 stop_seen_q, stop_seen_d;
  logic                 adc_prev_q;
  logic                 ready_q, ready_d;
  logic                 div_rst_n_q, div_rst_n_d;
  logic                 busy_q, busy_d;
  logic                 stb_q, stb_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic handshake;
  logic rise;
  logic len_hit;
  logic stop_pend;
  logic cnt_sat;
  logic wd_fire;

  assign handshake = cfg.cfg_valid & ready_q;
  assign rise      = adc_clk_in & ~adc_prev_q;
  assign len_hit   = (len_q != '0) && (cnt_q == len_q);
  // A stop_req arriving this cycle counts immediately; it is also latched for later cycles.
  assign stop_pend = stop_seen_q | stop_req | len_hit;
  // Only continuous bursts can reach all-ones; finite bursts stop at len first.
  assign cnt_sat   = (len_q == '0) && (cnt_q == '1);

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);

  logic [WdWidth-1:0] wd_q, wd_d;

  // Cycles in RUN since entry or the last rising edge; fires on the TIMEOUT-th such cycle.
  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if ((state_q == StRun) && !rise) begin
      if (wd_q == WdWidth'(TIMEOUT - 1)) begin
        wd_fire = 1'b1;
      end else begin
        wd_d = wd_q + WdWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout;

  assign wd_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    div_d       = div_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    stop_seen_d = stop_seen_q;
    stb_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d     = StArm;
          arm_cnt_d   = 1'b0;
          div_d       = cfg.cfg_div;
          len_d       = cfg.cfg_len;
          cnt_d       = '0;
          stop_seen_d = 1'b0;
        end
      end
      StArm: begin
        // Two cycles with the divider held in reset and the new ratio already applied.
        arm_cnt_d = 1'b1;
        if (arm_cnt_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (rise) begin
          stb_d = 1'b1;
          if (!cnt_sat) begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
        if (stop_req) begin
          stop_seen_d = 1'b1;
        end
        if (wd_fire) begin
          state_d = StStop;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (stop_pend && !adc_clk_in) begin
          // Leave only in a low phase so the divider never emits a truncated high pulse.
          state_d = StStop;
          done_d  = 1'b1;
        end
      end
      StStop: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d     = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    div_rst_n_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      arm_cnt_q   <= 1'b0;
      div_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      stop_seen_q <= 1'b0;
      adc_prev_q  <= 1'b0;
      ready_q     <= 1'b0;
      div_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      div_q       <= div_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      stop_seen_q <= stop_seen_d;
      adc_prev_q  <= adc_clk_in;
      ready_q     <= ready_d;
      div_rst_n_q <= div_rst_n_d;
      busy_q      <= busy_d;
      stb_q       <= stb_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign div_out       = div_q;
  assign div_rst_n     = div_rst_n_q;
  assign busy          = busy_q;
  assign sample_stb    = stb_q;
  assign sample_cnt    = cnt_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
